// File: rtl/bf_io_bridge_pkg.sv
// Shared types and constants for the bfX host I/O bridge.
package bf_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    ACK
  } bf_io_state_t;

  localparam logic       BF_IO_DIR_RD   = 1'b1;
  localparam logic       BF_IO_DIR_WR   = 1'b0;
  localparam logic [7:0] BF_IO_EOF_BYTE = 8'h00;

endpackage

// File: rtl/bf_io_bridge_fifo.sv
// Synchronous FIFO with occupancy count and a combinational head output.
// Push is ignored when full and pop is ignored when empty, using the flags
// sampled in the current cycle.
module bf_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bf_io_bridge.sv
// Host-side responder for the bfX core's ',' and '.' I/O requests.
// Optional: define BF_IO_EOF_EN to add host_eof, which completes reads on an
// empty input FIFO with the EOF byte instead of stalling.
module bf_io_bridge
  import bf_io_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_dir,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              host_in_valid,
  input  logic [DATA_W-1:0] host_in_data,
  output logic              host_in_ready,
  output logic              host_out_valid,
  output logic [DATA_W-1:0] host_out_data,
  input  logic              host_out_ready,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count
`ifdef BF_IO_EOF_EN
  ,
  input  logic              host_eof
`endif
);

  bf_io_state_t      state, state_nxt;
  logic              in_full, in_empty, out_full, out_empty;
  logic [DATA_W-1:0] in_head;
  logic              in_pop, out_push;
  logic              rdata_load, rdata_eof;
  logic              eof_in;

`ifdef BF_IO_EOF_EN
  assign eof_in = host_eof;
`else
  assign eof_in = 1'b0;
`endif

  assign host_in_ready  = !in_full;
  assign host_out_valid = !out_empty;
  assign cpu_ack        = (state == ACK);

  bf_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (host_in_valid),
    .push_data (host_in_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  bf_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (out_push),
    .push_data (cpu_wdata),
    .pop       (host_out_ready),
    .head      (host_out_data),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO strobes; IDLE and the wait states share the same
  // completion tests, the wait states simply skip the direction decode.
  always_comb begin
    state_nxt  = state;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    rdata_load = 1'b0;
    rdata_eof  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_dir == BF_IO_DIR_RD) begin
            if (!in_empty) begin
              in_pop     = 1'b1;
              rdata_load = 1'b1;
              state_nxt  = ACK;
            end else if (eof_in) begin
              rdata_eof  = 1'b1;
              state_nxt  = ACK;
            end else begin
              state_nxt  = RD_WAIT;
            end
          end else begin
            if (!out_full) begin
              out_push  = 1'b1;
              state_nxt = ACK;
            end else begin
              state_nxt = WR_WAIT;
            end
          end
        end
      end
      RD_WAIT: begin
        if (!in_empty) begin
          in_pop     = 1'b1;
          rdata_load = 1'b1;
          state_nxt  = ACK;
        end else if (eof_in) begin
          rdata_eof  = 1'b1;
          state_nxt  = ACK;
        end
      end
      WR_WAIT: begin
        if (!out_full) begin
          out_push  = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data register; holds until the next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cpu_rdata <= '0;
    else if (rdata_load) cpu_rdata <= in_head;
    else if (rdata_eof)  cpu_rdata <= DATA_W'(BF_IO_EOF_BYTE);
  end

endmodule

// File: tb/tb_bf_io_bridge.sv
// Directed self-checking bench for bf_io_bridge (DEPTH=8, DATA_W=8).
module tb_bf_io_bridge;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cpu_req;
  logic              cpu_dir;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              host_in_valid;
  logic [DATA_W-1:0] host_in_data;
  logic              host_in_ready;
  logic              host_out_valid;
  logic [DATA_W-1:0] host_out_data;
  logic              host_out_ready;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;
`ifdef BF_IO_EOF_EN
  logic              host_eof;
`endif

  int tests = 0;
  int fails = 0;

  bf_io_bridge #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req        (cpu_req),
    .cpu_dir        (cpu_dir),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ack        (cpu_ack),
    .host_in_valid  (host_in_valid),
    .host_in_data   (host_in_data),
    .host_in_ready  (host_in_ready),
    .host_out_valid (host_out_valid),
    .host_out_data  (host_out_data),
    .host_out_ready (host_out_ready),
    .in_count       (in_count),
    .out_count      (out_count)
`ifdef BF_IO_EOF_EN
    ,
    .host_eof       (host_eof)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a read and wait (bounded) for its ack.
  task automatic cpu_read(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    cpu_req = 1'b1;
    cpu_dir = 1'b1;
    do begin
      step();
      n++;
    end while (cpu_ack !== 1'b1 && n < 20);
    check({tag, "_ack"}, {31'd0, cpu_ack}, 32'd1);
    check({tag, "_data"}, {24'd0, cpu_rdata}, {24'd0, exp});
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    cpu_req        = 1'b0;
    cpu_dir        = 1'b0;
    cpu_wdata      = '0;
    host_in_valid  = 1'b0;
    host_in_data   = '0;
    host_out_ready = 1'b0;
`ifdef BF_IO_EOF_EN
    host_eof       = 1'b0;
`endif
    step();
    step();
    check("rst_ack",       {31'd0, cpu_ack}, 32'd0);
    check("rst_rdata",     {24'd0, cpu_rdata}, 32'd0);
    check("rst_in_count",  {28'd0, in_count}, 32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    check("rst_in_ready",  {31'd0, host_in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, host_out_valid}, 32'd0);
    rst_n = 1'b1;
    step();

    // Two host bytes, two reads.
    host_in_valid = 1'b1; host_in_data = 8'h41; step();
    host_in_data  = 8'h42; step();
    host_in_valid = 1'b0;
    check("t1_count2", {28'd0, in_count}, 32'd2);
    cpu_req = 1'b1; cpu_dir = 1'b1; step();
    check("t1_ack1",    {31'd0, cpu_ack}, 32'd1);
    check("t1_data1",   {24'd0, cpu_rdata}, 32'h41);
    check("t1_count1",  {28'd0, in_count}, 32'd1);
    cpu_req = 1'b0; step();
    check("t1_ack_low", {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b1; step();
    check("t1_ack2",    {31'd0, cpu_ack}, 32'd1);
    check("t1_data2",   {24'd0, cpu_rdata}, 32'h42);
    check("t1_count0",  {28'd0, in_count}, 32'd0);
    cpu_req = 1'b0; step();

    // Read on empty FIFO; host byte arrives 5 cycles later.
    cpu_req = 1'b1; cpu_dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_no_ack", {31'd0, cpu_ack}, 32'd0);
    end
    host_in_valid = 1'b1; host_in_data = 8'h7F; step();
    host_in_valid = 1'b0;
    check("t2_no_ack_push", {31'd0, cpu_ack}, 32'd0);
    check("t2_count1",      {28'd0, in_count}, 32'd1);
    step();
    check("t2_ack",    {31'd0, cpu_ack}, 32'd1);
    check("t2_data",   {24'd0, cpu_rdata}, 32'h7F);
    check("t2_count0", {28'd0, in_count}, 32'd0);
    cpu_req = 1'b0; step();

    // Eight writes fill the output FIFO.
    for (int i = 0; i < 8; i++) begin
      cpu_req = 1'b1; cpu_dir = 1'b0; cpu_wdata = 8'(i); step();
      check("t3_wr_ack", {31'd0, cpu_ack}, 32'd1);
      cpu_req = 1'b0; step();
    end
    check("t3_count8", {28'd0, out_count}, 32'd8);
    check("t3_valid",  {31'd0, host_out_valid}, 32'd1);
    check("t3_head0",  {24'd0, host_out_data}, 32'h00);
    // Ninth write stalls until the host frees one entry.
    cpu_req = 1'b1; cpu_wdata = 8'h08; step();
    check("t3_stall1", {31'd0, cpu_ack}, 32'd0);
    step();
    check("t3_stall2", {31'd0, cpu_ack}, 32'd0);
    host_out_ready = 1'b1; step();
    host_out_ready = 1'b0;
    check("t3_stall3",  {31'd0, cpu_ack}, 32'd0);
    check("t3_count7",  {28'd0, out_count}, 32'd7);
    check("t3_head1",   {24'd0, host_out_data}, 32'h01);
    step();
    check("t3_ack9",    {31'd0, cpu_ack}, 32'd1);
    check("t3_count8b", {28'd0, out_count}, 32'd8);
    cpu_req = 1'b0; step();
    host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t3_drain_valid", {31'd0, host_out_valid}, 32'd1);
      check("t3_drain_data",  {24'd0, host_out_data}, 32'(i));
      step();
    end
    host_out_ready = 1'b0;
    check("t3_empty", {28'd0, out_count}, 32'd0);
    check("t3_valid0", {31'd0, host_out_valid}, 32'd0);

    // Host offers nine bytes to an eight-entry FIFO.
    host_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_in_data = 8'h10 + 8'(i); step();
    end
    check("t4_ready0", {31'd0, host_in_ready}, 32'd0);
    check("t4_count8", {28'd0, in_count}, 32'd8);
    host_in_data = 8'h18; step(); step();
    check("t4_held",   {28'd0, in_count}, 32'd8);
    cpu_req = 1'b1; cpu_dir = 1'b1; step();
    cpu_req = 1'b0;
    check("t4_ack",    {31'd0, cpu_ack}, 32'd1);
    check("t4_data",   {24'd0, cpu_rdata}, 32'h10);
    check("t4_count7", {28'd0, in_count}, 32'd7);
    check("t4_ready1", {31'd0, host_in_ready}, 32'd1);
    step();
    host_in_valid = 1'b0;
    check("t4_count8b", {28'd0, in_count}, 32'd8);
    for (int i = 1; i <= 8; i++) cpu_read("t4_drain", 8'h10 + 8'(i));
    check("t4_count0", {28'd0, in_count}, 32'd0);

    // Asynchronous reset while a read waits.
    cpu_req = 1'b1; cpu_dir = 1'b0; cpu_wdata = 8'hA5; step();
    cpu_req = 1'b0; step();
    check("t5_out1", {28'd0, out_count}, 32'd1);
    cpu_req = 1'b1; cpu_dir = 1'b1; step(); step();
    check("t5_wait", {31'd0, cpu_ack}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_rdata", {24'd0, cpu_rdata}, 32'd0);
    check("t5_rst_out",   {28'd0, out_count}, 32'd0);
    check("t5_rst_valid", {31'd0, host_out_valid}, 32'd0);
    cpu_req = 1'b0;
    step();
    rst_n = 1'b1;
    host_in_valid = 1'b1; host_in_data = 8'h33; step();
    host_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_no_ack", {31'd0, cpu_ack}, 32'd0);
      step();
    end
    check("t5_count1", {28'd0, in_count}, 32'd1);
    cpu_read("t5_read", 8'h33);

`ifdef BF_IO_EOF_EN
    host_eof = 1'b1;
    cpu_req = 1'b1; cpu_dir = 1'b1; step();
    check("eof_ack",  {31'd0, cpu_ack}, 32'd1);
    check("eof_data", {24'd0, cpu_rdata}, 32'h00);
    cpu_req = 1'b0; step();
    host_in_valid = 1'b1; host_in_data = 8'h55; step();
    host_in_valid = 1'b0;
    cpu_req = 1'b1; step();
    check("eof_fifo_ack",  {31'd0, cpu_ack}, 32'd1);
    check("eof_fifo_data", {24'd0, cpu_rdata}, 32'h55);
    cpu_req = 1'b0; host_eof = 1'b0; step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
